cpu_run_ctrl: RTL and testbench

//  Sequencer for the 8-bit accumulator CPU. Loads a program byte-stream from the UART receiver into the
//  32x8 instruction memory, zero-fills (HLT) unused words, then gates CPU execution: free-run until HLT,
//  or single-step one instruction per request. Owns cpu_load/cpu_en/cpu_clr; the CPU datapath is unchanged.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/cpu_run_ctrl_idle_timer.sv | 31 +++
 rtl/cpu_run_ctrl.sv | 143 ++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator-CPU run controller.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FILL  = 3'd2,
    ST_READY = 3'd3,
    ST_RUN   = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam int IMEM_DEPTH = 32;
  localparam int DEF_UBRR = 325;
  localparam int DEF_IDLE_TMO = 52080;

endpackage

// File: rtl/cpu_run_ctrl_idle_timer.sv
// Idle timeout for program load: down-counter reloaded on every received
// byte, flags the last cycle of an IDLE_TMO-cycle quiet gap.
module cpu_run_ctrl_idle_timer import cpu_pkg::*; #(
  parameter int IDLE_TMO = DEF_IDLE_TMO
) (
  input  logic Clk,
  input  logic Reset,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int TW = $clog2(IDLE_TMO + 1);
  localparam logic [TW-1:0] TMO_VAL = TW'(IDLE_TMO);

  logic [TW-1:0] cnt;

  // Reload while not timing, otherwise count quiet cycles down towards 1.
  always_ff @(posedge Clk) begin
    if (Reset)
      cnt <= '0;
    else if (load)
      cnt <= TMO_VAL;
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  // cnt==1 marks the IDLE_TMO-th consecutive quiet cycle.
  assign tc = en && !load && (cnt == TW'(1));

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 8-bit accumulator CPU: loads the program from the
// UART into instruction memory, zero-fills the rest, then gates execution
// as free-run or single-step.
//
// state | meaning
// IDLE  | nothing loaded since reset; run/step ignored
// LOAD  | writing received bytes at ptr, CPU held in load
// FILL  | writing HLT (8'h00) from ptr up to the last word
// READY | program loaded, CPU stopped at PC 0
// RUN   | CPU enabled every cycle until HLT is seen
// HALT  | CPU stopped on HLT (or step into HLT)
// ERR   | framing error during load; only a new load exits
module cpu_run_ctrl import cpu_pkg::*; #(
  parameter int ADDR_W   = $clog2(IMEM_DEPTH),
  parameter int DATA_W   = 8,
  parameter int IDLE_TMO = DEF_IDLE_TMO
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_fe,
  input  logic [2:0]        opcode,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_load,
  output logic              cpu_en,
  output logic              cpu_clr,
  output logic [ADDR_W:0]   prog_len,
  output logic              err,
  output logic              busy
);

  state_t          state;
  logic [ADDR_W:0] ptr;
  logic            step_q;
  logic            tmo_load;
  logic            tmo_en;
  logic            tmo_hit;

  // Timer only runs in LOAD once a byte has arrived; each byte restarts it.
  assign tmo_load = (state != ST_LOAD) || rx_valid;
  assign tmo_en   = (state == ST_LOAD) && (ptr != '0);

  cpu_run_ctrl_idle_timer #(.IDLE_TMO(IDLE_TMO)) u_idle_timer (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (tmo_load),
    .en    (tmo_en),
    .tc    (tmo_hit)
  );

  // Memory write port follows the incoming strobe in the same cycle; Reset
  // blocks the write immediately so an aborted load leaves no extra word.
  always_comb begin
    imem_we    = 1'b0;
    imem_wdata = '0;
    if (!Reset) begin
      if (state == ST_LOAD && rx_valid && !rx_fe) begin
        imem_we    = 1'b1;
        imem_wdata = rx_data;
      end else if (state == ST_FILL) begin
        imem_we = 1'b1;
      end
    end
  end

  assign imem_addr = ptr[ADDR_W-1:0];
  assign busy      = (state == ST_LOAD) || (state == ST_FILL);
  assign cpu_load  = busy || (state == ST_ERR);
  // HLT must stop the CPU in the very cycle it is presented, hence combinational.
  assign cpu_en    = ((state == ST_RUN) && (opcode != OP_HLT)) || step_q;

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      prog_len <= '0;
      err      <= 1'b0;
      cpu_clr  <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      cpu_clr <= 1'b0;
      step_q  <= 1'b0;
      if (load_req && !busy) begin
        state <= ST_LOAD;
        ptr   <= '0;
        err   <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (rx_valid) begin
              if (rx_fe) begin
                err   <= 1'b1;
                state <= ST_ERR;
              end else if (&ptr[ADDR_W-1:0]) begin
                prog_len <= ptr + 1'b1;
                ptr      <= '0;
                cpu_clr  <= 1'b1;
                state    <= ST_READY;
              end else begin
                ptr <= ptr + 1'b1;
              end
            end else if (tmo_hit) begin
              prog_len <= ptr;
              state    <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (&ptr[ADDR_W-1:0]) begin
              ptr     <= '0;
              cpu_clr <= 1'b1;
              state   <= ST_READY;
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
          ST_READY, ST_HALT: begin
            if (run_req)
              state <= ST_RUN;
            else if (step_req && !step_q) begin
              if (opcode == OP_HLT)
                state <= ST_HALT;
              else
                step_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (opcode == OP_HLT)
              state <= ST_HALT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a short idle timeout.
module tb_cpu_run_ctrl;
  import cpu_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 8;
  localparam int IDLE_TMO = 20;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              load_req = 1'b0;
  logic              run_req = 1'b0;
  logic              step_req = 1'b0;
  logic              rx_valid = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_fe = 1'b0;
  logic [2:0]        opcode = 3'b001;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_load;
  logic              cpu_en;
  logic              cpu_clr;
  logic [ADDR_W:0]   prog_len;
  logic              err;
  logic              busy;

  int n_cmp = 0;
  int n_mis = 0;
  int wr_cnt = 0;
  int clr_cnt = 0;
  int en_cnt = 0;
  logic [7:0] shadow [32] = '{default: 8'hFF};

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDLE_TMO(IDLE_TMO)) dut (
    .Clk(Clk), .Reset(Reset), .load_req(load_req), .run_req(run_req),
    .step_req(step_req), .rx_valid(rx_valid), .rx_data(rx_data), .rx_fe(rx_fe),
    .opcode(opcode), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_load(cpu_load), .cpu_en(cpu_en),
    .cpu_clr(cpu_clr), .prog_len(prog_len), .err(err), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Log memory writes and pulse counts mid-cycle.
  always @(negedge Clk) begin
    if (imem_we) begin
      shadow[imem_addr] = imem_wdata;
      wr_cnt++;
    end
    if (cpu_clr) clr_cnt++;
    if (cpu_en) en_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic fe);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_fe    = fe;
    tick();
    rx_valid = 1'b0;
    rx_fe    = 1'b0;
  endtask

  task automatic wait_state(input state_t s, input int lim, input string tag);
    for (int i = 0; i < lim; i++) begin
      if (dut.state == s) break;
      tick();
    end
    check(tag, 32'(dut.state), 32'(s));
  endtask

  initial begin
    int wb, cb, eb, bad;

    // Reset
    tick(); tick();
    check("rst_outs", {23'd0, imem_we, cpu_load, cpu_en, cpu_clr, err, busy, prog_len}, 32'd0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    Reset = 1'b0;
    tick();
    run_req = 1'b1; tick(); run_req = 1'b0;
    check("idle_run_ign", 32'(dut.state), 32'(ST_IDLE));

    // 1: short program, timeout, zero fill
    wb = wr_cnt; cb = clr_cnt;
    load_req = 1'b1; tick(); load_req = 1'b0;
    check("t1_busy_load", {30'd0, busy, cpu_load}, 32'd3);
    send_byte(8'hA1, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'hE5, 1'b0);
    repeat (19) tick();
    check("t1_tmo_not_yet", 32'(dut.state), 32'(ST_LOAD));
    tick();
    check("t1_fill", 32'(dut.state), 32'(ST_FILL));
    check("t1_fill_addr", 32'(imem_addr), 32'd3);
    wait_state(ST_READY, 40, "t1_ready");
    check("t1_clr", 32'(cpu_clr), 32'd1);
    tick();
    check("t1_clr_once", 32'(clr_cnt - cb), 32'd1);
    check("t1_wr_cnt", 32'(wr_cnt - wb), 32'd32);
    check("t1_len", 32'(prog_len), 32'd3);
    check("t1_busy_fall", {30'd0, busy, cpu_load}, 32'd0);
    check("t1_data", {8'd0, shadow[0], shadow[1], shadow[2]}, 32'h00A122E5);
    bad = 0;
    for (int i = 3; i < 32; i++) if (shadow[i] !== 8'h00) bad++;
    check("t1_zero_fill", 32'(bad), 32'd0);

    // 4: free run until HLT
    opcode = 3'b011;
    eb = en_cnt;
    run_req = 1'b1; tick(); run_req = 1'b0;
    check("t4_run", 32'(dut.state), 32'(ST_RUN));
    check("t4_en_on", 32'(cpu_en), 32'd1);
    step_req = 1'b1; tick(); step_req = 1'b0;
    check("t4_step_ign", 32'(dut.state), 32'(ST_RUN));
    repeat (4) tick();
    opcode = 3'b000;
    #1;
    check("t4_en_hlt_comb", 32'(cpu_en), 32'd0);
    tick();
    check("t4_halt", 32'(dut.state), 32'(ST_HALT));
    check("t4_en_cycles", 32'(en_cnt - eb), 32'd5);

    // 2: full 32-byte program, no fill
    load_req = 1'b1; tick(); load_req = 1'b0;
    wb = wr_cnt;
    for (int i = 0; i < 32; i++) send_byte(8'(i * 7 + 3), 1'b0);
    check("t2_ready", 32'(dut.state), 32'(ST_READY));
    check("t2_clr", 32'(cpu_clr), 32'd1);
    check("t2_len", 32'(prog_len), 32'd32);
    check("t2_wr_cnt", 32'(wr_cnt - wb), 32'd32);
    bad = 0;
    for (int i = 0; i < 32; i++) if (shadow[i] !== 8'(i * 7 + 3)) bad++;
    check("t2_data", 32'(bad), 32'd0);

    // 5: single step
    opcode = 3'b101;
    eb = en_cnt;
    step_req = 1'b1; tick(); step_req = 1'b0;
    check("t5_pulse1", 32'(cpu_en), 32'd1);
    check("t5_stay", 32'(dut.state), 32'(ST_READY));
    tick();
    check("t5_pulse_end", 32'(cpu_en), 32'd0);
    repeat (3) tick();
    step_req = 1'b1; tick(); step_req = 1'b0;
    tick();
    check("t5_two_pulses", 32'(en_cnt - eb), 32'd2);
    opcode = 3'b000;
    step_req = 1'b1; tick(); step_req = 1'b0;
    check("t5_hlt_noen", 32'(cpu_en), 32'd0);
    check("t5_halt", 32'(dut.state), 32'(ST_HALT));
    tick();
    check("t5_en_total", 32'(en_cnt - eb), 32'd2);

    // 6: priority in HALT, then reset during fill
    load_req = 1'b1; run_req = 1'b1; tick(); load_req = 1'b0; run_req = 1'b0;
    check("t6_prio", 32'(dut.state), 32'(ST_LOAD));
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    wait_state(ST_FILL, 40, "t6_fill");
    for (int i = 0; i < 40; i++) begin
      if (imem_addr == 5'd10) break;
      tick();
    end
    check("t6_addr10", 32'(imem_addr), 32'd10);
    Reset = 1'b1;
    #1;
    check("t6_we_in_rst", 32'(imem_we), 32'd0);
    wb = wr_cnt;
    tick();
    Reset = 1'b0;
    repeat (3) tick();
    check("t6_no_wr", 32'(wr_cnt - wb), 32'd0);
    check("t6_idle", 32'(dut.state), 32'(ST_IDLE));
    check("t6_len0", 32'(prog_len), 32'd0);

    // 3: framing error on third byte
    load_req = 1'b1; tick(); load_req = 1'b0;
    wb = wr_cnt;
    send_byte(8'h5A, 1'b0);
    send_byte(8'h6B, 1'b0);
    send_byte(8'h7C, 1'b1);
    check("t3_err_state", 32'(dut.state), 32'(ST_ERR));
    check("t3_flags", {29'd0, err, cpu_load, cpu_en}, 32'd6);
    check("t3_wr_cnt", 32'(wr_cnt - wb), 32'd2);
    run_req = 1'b1; tick(); run_req = 1'b0;
    check("t3_run_ign", 32'(dut.state), 32'(ST_ERR));
    load_req = 1'b1; tick(); load_req = 1'b0;
    check("t3_err_clr", 32'(err), 32'd0);
    check("t3_reload", 32'(dut.state), 32'(ST_LOAD));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
